udp_tx_packer: RTL and testbench

Transmit-side counterpart of the UDP receive path. It accepts a 32-bit payload stream from the SRIO side, stores one whole packet, and counts its bytes. It then emits an 8-bit UDP byte stream made of the 8-byte UDP header (source port, destination port, length, checksum = 0) followed by the payload, MSB byte first. It sits between the SRIO response logic and the 8-bit UDP/IP transmit pipeline, single clock domain.

---
 rtl/udp_pkg.sv | 40 ++++
 rtl/udp_tx_buffer_ram.sv | 30 +++
 rtl/udp_tx_packer.sv | 204 ++++++++++++++++++++
 tb/tb_udp_tx_packer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit packer: header size, FSM encoding,
// tkeep decoding and header byte selection.
package udp_pkg;

  localparam int UDP_HDR_BYTES = 8;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // Leading ones from bit 3 give the valid byte count of the last beat.
  function automatic logic [2:0] keep_to_bytes(input logic [3:0] keep);
    logic [2:0] n;
    casez (keep)
      4'b1111: n = 3'd4;
      4'b1110: n = 3'd3;
      4'b110?: n = 3'd2;
      4'b10??: n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] src,
                                          input logic [15:0] dst, input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      3'd0:    b = src[15:8];
      3'd1:    b = src[7:0];
      3'd2:    b = dst[15:8];
      3'd3:    b = dst[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_tx_buffer_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
module udp_tx_buffer_ram #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_data;

  // Storage write and one-cycle-latency read.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/udp_tx_packer.sv
// Buffers one 32-bit payload packet, then emits it as an 8-bit UDP datagram:
// 8-byte header (checksum zero) followed by the payload, MSB byte first.
module udp_tx_packer
  import udp_pkg::*;
#(
  parameter int DEPTH_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] udp_length_out,
  output logic        pkt_drop
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = AW + 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_wcnt;
  logic [15:0]   r_pay_bytes;
  logic [15:0]   r_len;
  logic [15:0]   r_src;
  logic [15:0]   r_dst;
  logic [2:0]    r_hcnt;
  logic [15:0]   r_nidx;
  logic          r_s_tready;
  logic [7:0]    r_m_tdata;
  logic          r_m_tvalid;
  logic          r_m_tlast;
  logic          r_pkt_drop;

  logic          w_s_hs;
  logic          w_m_hs;
  logic          w_full;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_adv;
  logic [15:0]   w_rd_idx;
  logic [AW-1:0] w_rd_addr;
  logic [31:0]   w_rd_data;
  logic [15:0]   w_last_bytes;
  logic [15:0]   w_len;
  logic [7:0]    w_pay_byte;

  assign w_s_hs       = s_axis_tvalid & r_s_tready;
  assign w_m_hs       = r_m_tvalid & m_axis_tready;
  assign w_full       = (r_wcnt == CW'(DEPTH_WORDS));
  assign w_wr_en      = w_s_hs & (r_state == ST_FILL) & ~w_full;
  assign w_last_bytes = 16'({r_wcnt, 2'b00}) + 16'(keep_to_bytes(s_axis_tkeep));
  assign w_len        = w_last_bytes + 16'(UDP_HDR_BYTES);

  // The read register always holds the word of r_nidx, the next byte to load;
  // on a load the address jumps ahead so the following word is ready in time.
  assign w_adv     = w_m_hs & ((r_state == ST_PAY) | ((r_state == ST_HDR) & (r_hcnt == 3'd7)));
  assign w_rd_idx  = w_adv ? (r_nidx + 16'd1) : r_nidx;
  assign w_rd_addr = AW'(w_rd_idx >> 2);
  assign w_rd_en   = (r_state == ST_HDR) | (r_state == ST_PAY);

  udp_tx_buffer_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wcnt[AW-1:0]),
    .i_wr_data (s_axis_tdata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Byte-lane select of the buffered word, lane 0 on the MSBs.
  always_comb begin
    w_pay_byte = 8'h00;
    case (r_nidx[1:0])
      2'd0:    w_pay_byte = w_rd_data[31:24];
      2'd1:    w_pay_byte = w_rd_data[23:16];
      2'd2:    w_pay_byte = w_rd_data[15:8];
      default: w_pay_byte = w_rd_data[7:0];
    endcase
  end

  // Packet FSM, counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_wcnt      <= '0;
      r_pay_bytes <= 16'd0;
      r_len       <= 16'd0;
      r_src       <= 16'd0;
      r_dst       <= 16'd0;
      r_hcnt      <= 3'd0;
      r_nidx      <= 16'd0;
      r_s_tready  <= 1'b0;
      r_m_tdata   <= 8'h00;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_pkt_drop  <= 1'b0;
    end else begin
      r_pkt_drop <= 1'b0;
      case (r_state)
        ST_FILL: begin
          r_s_tready <= 1'b1;
          if (w_s_hs) begin
            if (w_full) begin
              r_wcnt <= '0;
              if (s_axis_tlast) begin
                r_pkt_drop <= 1'b1;
              end else begin
                r_state <= ST_DROP;
              end
            end else if (s_axis_tlast) begin
              r_wcnt      <= '0;
              r_pay_bytes <= w_last_bytes;
              r_len       <= w_len;
              r_src       <= src_port;
              r_dst       <= dst_port;
              r_hcnt      <= 3'd0;
              r_nidx      <= 16'd0;
              r_m_tdata   <= hdr_byte(3'd0, src_port, dst_port, w_len);
              r_m_tvalid  <= 1'b1;
              r_m_tlast   <= 1'b0;
              r_s_tready  <= 1'b0;
              r_state     <= ST_HDR;
            end else begin
              r_wcnt <= r_wcnt + CW'(1);
            end
          end
        end
        ST_HDR: begin
          if (w_m_hs) begin
            if (r_hcnt == 3'd7) begin
              if (r_pay_bytes == 16'd0) begin
                r_state    <= ST_FILL;
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
                r_m_tdata  <= 8'h00;
                r_len      <= 16'd0;
                r_s_tready <= 1'b1;
              end else begin
                r_state   <= ST_PAY;
                r_m_tdata <= w_pay_byte;
                r_m_tlast <= (r_pay_bytes == 16'd1);
                r_nidx    <= r_nidx + 16'd1;
              end
            end else begin
              r_hcnt    <= r_hcnt + 3'd1;
              r_m_tdata <= hdr_byte(r_hcnt + 3'd1, r_src, r_dst, r_len);
              r_m_tlast <= (r_hcnt == 3'd6) && (r_pay_bytes == 16'd0);
            end
          end
        end
        ST_PAY: begin
          if (w_m_hs) begin
            if (r_m_tlast) begin
              r_state    <= ST_FILL;
              r_m_tvalid <= 1'b0;
              r_m_tlast  <= 1'b0;
              r_m_tdata  <= 8'h00;
              r_len      <= 16'd0;
              r_s_tready <= 1'b1;
            end else begin
              r_m_tdata <= w_pay_byte;
              r_m_tlast <= (r_nidx == (r_pay_bytes - 16'd1));
              r_nidx    <= r_nidx + 16'd1;
            end
          end
        end
        ST_DROP: begin
          r_s_tready <= 1'b1;
          if (w_s_hs && s_axis_tlast) begin
            r_pkt_drop <= 1'b1;
            r_state    <= ST_FILL;
          end
        end
        default: begin
          r_state    <= ST_FILL;
          r_wcnt     <= '0;
          r_m_tvalid <= 1'b0;
          r_m_tlast  <= 1'b0;
          r_s_tready <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready  = r_s_tready;
  assign m_axis_tdata   = r_m_tdata;
  assign m_axis_tvalid  = r_m_tvalid;
  assign m_axis_tlast   = r_m_tlast;
  assign udp_length_out = r_len;
  assign pkt_drop       = r_pkt_drop;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Directed bench for udp_tx_packer with a small buffer so overflow can be exercised.
module tb_udp_tx_packer;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] udp_length_out;
  logic        pkt_drop;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_last  = 0;
  int n_drop  = 0;
  int drop_cyc = -1;
  int last_hs_cyc = 0;
  logic tog_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_out = 10'd0;

  logic [7:0]  q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic [15:0] q_len[$];
  logic [31:0] wbuf[8];

  udp_tx_packer #(.DEPTH_WORDS(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .src_port       (src_port),
    .dst_port       (dst_port),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .udp_length_out (udp_length_out),
    .pkt_drop       (pkt_drop)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor on the falling edge: records handshakes, drops, checks stall hold.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, prev_out});
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(cyc);
        q_len.push_back(udp_length_out);
        if (m_axis_tlast) n_last++;
      end
      if (pkt_drop) begin
        n_drop++;
        drop_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = tog_en ? ~m_axis_tready : 1'b1;
    end
  end

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    q_len.delete();
  endtask

  // Non-last beats carry a junk tkeep that must be ignored.
  task automatic send_pkt(input int nb, input logic [3:0] keep, input logic [15:0] src,
                          input logic [15:0] dst);
    int k;
    src_port = src;
    dst_port = dst;
    for (int i = 0; i < nb; i++) begin
      k = 0;
      s_axis_tdata  = wbuf[i];
      s_axis_tkeep  = (i == nb - 1) ? keep : 4'b0101;
      s_axis_tlast  = (i == nb - 1);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!s_axis_tready) chk("s_ready_timeout", {31'd0, s_axis_tready}, 32'd1);
      last_hs_cyc = cyc + 1;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_last(input int target);
    int k;
    k = 0;
    while (n_last < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", n_last, target);
    @(posedge clk);
    #1;
    chk("tready_after_pkt", {31'd0, s_axis_tready}, 32'd1);
  endtask

  task automatic check_pkt(input string nm, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len);
    logic [7:0] exp_b[$];
    int j;
    exp_b = {src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'h00, 8'h00};
    for (j = 0; j < int'(len) - 8; j++) exp_b.push_back(wbuf[j / 4][31 - 8 * (j % 4) -: 8]);
    chk({nm, "_nbytes"}, q_data.size(), len);
    for (int i = 0; i < q_data.size() && i < exp_b.size(); i++) begin
      chk($sformatf("%s_byte%0d", nm, i), {24'd0, q_data[i]}, {24'd0, exp_b[i]});
      chk($sformatf("%s_tlast%0d", nm, i), {31'd0, q_last[i]}, {31'd0, (i == exp_b.size() - 1)});
    end
    if (q_len.size() > 0) chk({nm, "_len_out"}, {16'd0, q_len[0]}, {16'd0, len});
  endtask

  initial begin
    int nl;
    int nd;
    reset = 1'b1;
    s_axis_tdata = 32'd0;
    s_axis_tkeep = 4'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    src_port = 16'd0;
    dst_port = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_len", {16'd0, udp_length_out}, 32'd0);
    chk("rst_drop", {31'd0, pkt_drop}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
    @(posedge clk);
    #1;

    // Single beat, full keep: 12 34 56 78 00 0C 00 00 DE AD BE EF
    clear_q();
    wbuf[0] = 32'hDEADBEEF;
    nl = n_last;
    send_pkt(1, 4'b1111, 16'h1234, 16'h5678);
    wait_last(nl + 1);
    check_pkt("t1", 16'h1234, 16'h5678, 16'h000C);
    if (q_cyc.size() == 12) begin
      chk("t1_first_cycle", q_cyc[0], last_hs_cyc);
      chk("t1_back_to_back", q_cyc[11] - q_cyc[0], 32'd11);
      chk("t1_last_byte", {24'd0, q_data[11]}, 32'h000000EF);
    end

    // Three beats, last keep 1100: 10 payload bytes, length 18
    clear_q();
    wbuf[0] = 32'h01020304;
    wbuf[1] = 32'h05060708;
    wbuf[2] = 32'h090A0B0C;
    nl = n_last;
    send_pkt(3, 4'b1100, 16'hC000, 16'h0007);
    wait_last(nl + 1);
    check_pkt("t2", 16'hC000, 16'h0007, 16'h0012);

    // Empty payload: header only, tlast on header byte 7
    clear_q();
    wbuf[0] = 32'hCAFEF00D;
    nl = n_last;
    send_pkt(1, 4'b0000, 16'h1111, 16'h2222);
    wait_last(nl + 1);
    check_pkt("t3", 16'h1111, 16'h2222, 16'h0008);

    // Downstream stalling every other cycle on a 2-word packet
    clear_q();
    wbuf[0] = 32'hA1B2C3D4;
    wbuf[1] = 32'h55667788;
    nl = n_last;
    tog_en = 1'b1;
    send_pkt(2, 4'b1111, 16'h0400, 16'h0035);
    wait_last(nl + 1);
    tog_en = 1'b0;
    check_pkt("t4", 16'h0400, 16'h0035, 16'h0010);
    repeat (2) @(posedge clk);
    #1;

    // Oversize 6-beat packet is dropped with a single pulse
    clear_q();
    for (int i = 0; i < 6; i++) wbuf[i] = 32'h70000000 + i;
    nd = n_drop;
    send_pkt(6, 4'b1111, 16'h0A0A, 16'h0B0B);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_drop_count", n_drop - nd, 32'd1);
    chk("t5_drop_cycle", drop_cyc, last_hs_cyc);
    chk("t5_no_output", q_data.size(), 32'd0);

    // Following 1-word packet with a single payload byte
    clear_q();
    wbuf[0] = 32'h0BADF00D;
    nl = n_last;
    send_pkt(1, 4'b1000, 16'h0F0F, 16'hF0F0);
    wait_last(nl + 1);
    check_pkt("t5b", 16'h0F0F, 16'hF0F0, 16'h0009);

    // Overflow on the tlast beat itself (5 beats into 4 words)
    clear_q();
    nd = n_drop;
    send_pkt(5, 4'b1111, 16'h0001, 16'h0002);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_drop_count", n_drop - nd, 32'd1);
    chk("t6_drop_cycle", drop_cyc, last_hs_cyc);
    chk("t6_no_output", q_data.size(), 32'd0);

    // Reset in the middle of the payload
    clear_q();
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'h55667788;
    wbuf[2] = 32'h99AABBCC;
    nd = n_drop;
    nl = n_last;
    send_pkt(3, 4'b1111, 16'h2000, 16'h3000);
    begin
      int k;
      k = 0;
      while (q_data.size() < 10 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t7_reached_pay", {31'd0, (q_data.size() >= 10)}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t7_rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("t7_rst_len", {16'd0, udp_length_out}, 32'd0);
    chk("t7_rst_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t7_post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
    chk("t7_no_drop", n_drop - nd, 32'd0);
    chk("t7_no_tlast", n_last - nl, 32'd0);
    @(posedge clk);
    #1;
    clear_q();
    wbuf[0] = 32'h13579BDF;
    nl = n_last;
    send_pkt(1, 4'b1110, 16'hABCD, 16'h0102);
    wait_last(nl + 1);
    check_pkt("t7b", 16'hABCD, 16'h0102, 16'h000B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
